// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with registered
// visible, sync, blank and frame-start indications plus a frame counter.
// Counters and VISIBLE/FRAME_START share one timing stage; HSYNC, VSYNC and
// BLANK trail them by one clock to line up with a registered colour stage.
module vga_timing_gen #(
   parameter int H_VISIBLE = 800,
   parameter int H_FRONT   = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BACK    = 88,
   parameter int V_VISIBLE = 600,
   parameter int V_FRONT   = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BACK    = 23,
   parameter bit SYNC_POL  = 1'b1
) (
   input  logic        VGA_CLOCK,
   input  logic        RESET,
   output logic [10:0] PIXEL_H,
   output logic [10:0] PIXEL_V,
   output logic        VISIBLE,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        BLANK,
   output logic        FRAME_START,
   output logic [7:0]  FRAME_COUNT
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
   localparam logic [10:0] H_SYNC_FIRST = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] V_SYNC_FIRST = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic        h_wrap;
   logic        v_wrap;
   logic        frame_wrap;
   logic [10:0] h_next;
   logic [10:0] v_next;
   logic        h_in_sync;
   logic        v_in_sync;

   // Next counter position and the wrap/sync decodes of the current position
   always_comb begin
      h_wrap     = (PIXEL_H == H_LAST);
      v_wrap     = (PIXEL_V == V_LAST);
      frame_wrap = h_wrap && v_wrap;
      h_next     = h_wrap ? 11'd0 : PIXEL_H + 11'd1;
      v_next     = PIXEL_V;
      if (h_wrap) begin
         v_next = v_wrap ? 11'd0 : PIXEL_V + 11'd1;
      end
      h_in_sync  = (PIXEL_H >= H_SYNC_FIRST) && (PIXEL_H <= H_SYNC_LAST);
      v_in_sync  = (PIXEL_V >= V_SYNC_FIRST) && (PIXEL_V <= V_SYNC_LAST);
   end

   // Pixel and line counters; the frame begun by reset starts at (0,0)
   always_ff @(posedge VGA_CLOCK or negedge RESET) begin
      if (!RESET) begin
         PIXEL_H <= 11'd0;
         PIXEL_V <= 11'd0;
      end else begin
         PIXEL_H <= h_next;
         PIXEL_V <= v_next;
      end
   end

   // Visible flag and frame markers computed from the next position so they land with the counters
   always_ff @(posedge VGA_CLOCK or negedge RESET) begin
      if (!RESET) begin
         VISIBLE     <= 1'b1;
         FRAME_START <= 1'b0;
         FRAME_COUNT <= 8'd0;
      end else begin
         VISIBLE     <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
         FRAME_START <= frame_wrap;
         if (frame_wrap) begin
            FRAME_COUNT <= FRAME_COUNT + 8'd1;
         end
      end
   end

   // Sync and blank trail the counters by one clock to match the colour pipeline stage
   always_ff @(posedge VGA_CLOCK or negedge RESET) begin
      if (!RESET) begin
         HSYNC <= ~SYNC_POL;
         VSYNC <= ~SYNC_POL;
         BLANK <= 1'b1;
      end else begin
         HSYNC <= h_in_sync ? SYNC_POL : ~SYNC_POL;
         VSYNC <= v_in_sync ? SYNC_POL : ~SYNC_POL;
         BLANK <= ~VISIBLE;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one default-timing instance for line-level
// behaviour and one small-timing instance for frame-level behaviour.
module tb_vga_timing_gen;

   logic        VGA_CLOCK;
   logic        rst_big;
   logic        rst_small;

   logic [10:0] d_h, d_v;
   logic        d_visible, d_hsync, d_vsync, d_blank, d_fs;
   logic [7:0]  d_fc;

   logic [10:0] s_h, s_v;
   logic        s_visible, s_hsync, s_vsync, s_blank, s_fs;
   logic [7:0]  s_fc;

   int total_checks = 0;
   int pass_checks  = 0;

   // small-instance tracking
   int   sk = 0;
   int   inv_err = 0;
   logic prev_vis = 1'b1;
   int   pulses = 0;
   int   last_pulse_k = -1;
   int   last_gap = 0;
   int   vs_cnt = 0;
   int   vis_cnt = 0;

   vga_timing_gen dut_big (
      .VGA_CLOCK   (VGA_CLOCK),
      .RESET       (rst_big),
      .PIXEL_H     (d_h),
      .PIXEL_V     (d_v),
      .VISIBLE     (d_visible),
      .HSYNC       (d_hsync),
      .VSYNC       (d_vsync),
      .BLANK       (d_blank),
      .FRAME_START (d_fs),
      .FRAME_COUNT (d_fc)
   );

   // small frame: H_TOTAL 15 (sync 10..12), V_TOTAL 10 (sync 7..8), 150 clocks/frame
   vga_timing_gen #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .SYNC_POL  (1'b1)
   ) dut_small (
      .VGA_CLOCK   (VGA_CLOCK),
      .RESET       (rst_small),
      .PIXEL_H     (s_h),
      .PIXEL_V     (s_v),
      .VISIBLE     (s_visible),
      .HSYNC       (s_hsync),
      .VSYNC       (s_vsync),
      .BLANK       (s_blank),
      .FRAME_START (s_fs),
      .FRAME_COUNT (s_fc)
   );

   // 10 ns pixel clock
   initial begin
      VGA_CLOCK = 1'b0;
      forever #5 VGA_CLOCK = ~VGA_CLOCK;
   end

   // hard stop in case the flow ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      if (observed === expected) begin
         pass_checks++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // one small-instance clock: invariants, position model, pulse and window statistics
   task automatic stepSmall();
      @(negedge VGA_CLOCK);
      sk++;
      if (s_h >= 11'd15 || s_v >= 11'd10) inv_err++;
      if (s_h !== 11'(sk % 15) || s_v !== 11'((sk / 15) % 10)) inv_err++;
      if (s_blank !== ~prev_vis) inv_err++;
      prev_vis = s_visible;
      if (s_fs) begin
         pulses++;
         if (last_pulse_k >= 0) last_gap = sk - last_pulse_k;
         last_pulse_k = sk;
      end
      if (sk >= 151 && sk <= 300) begin
         if (s_vsync) vs_cnt++;
         if (s_visible) vis_cnt++;
      end
   endtask

   task automatic stepTo(input int target);
      while (sk < target) stepSmall();
   endtask

   task automatic checkResetState(input string pfx);
      checkOutput({pfx, "_h"},       32'(s_h),       32'd0);
      checkOutput({pfx, "_v"},       32'(s_v),       32'd0);
      checkOutput({pfx, "_visible"}, 32'(s_visible), 32'd1);
      checkOutput({pfx, "_hsync"},   32'(s_hsync),   32'd0);
      checkOutput({pfx, "_vsync"},   32'(s_vsync),   32'd0);
      checkOutput({pfx, "_blank"},   32'(s_blank),   32'd1);
      checkOutput({pfx, "_fs"},      32'(s_fs),      32'd0);
      checkOutput({pfx, "_fc"},      32'(s_fc),      32'd0);
   endtask

   task automatic applyStimulus();
      int big_err;
      int hs_cnt;
      big_err = 0;
      hs_cnt  = 0;

      // both instances held in reset; sample between edges
      rst_big   = 1'b0;
      rst_small = 1'b0;
      #23;
      checkOutput("rst_h",       32'(d_h),       32'd0);
      checkOutput("rst_v",       32'(d_v),       32'd0);
      checkOutput("rst_visible", 32'(d_visible), 32'd1);
      checkOutput("rst_hsync",   32'(d_hsync),   32'd0);
      checkOutput("rst_vsync",   32'(d_vsync),   32'd0);
      checkOutput("rst_blank",   32'(d_blank),   32'd1);
      checkOutput("rst_fs",      32'(d_fs),      32'd0);
      checkOutput("rst_fc",      32'(d_fc),      32'd0);

      // default-timing line walk
      @(negedge VGA_CLOCK);
      rst_big = 1'b1;
      for (int k = 1; k <= 1060; k++) begin
         @(negedge VGA_CLOCK);
         if (d_h !== 11'(k % 1056) || d_v !== 11'(k / 1056)) big_err++;
         if (k <= 1056 && d_hsync) hs_cnt++;
         case (k)
            1:    checkOutput("first_h",        32'(d_h),       32'd1);
            799:  checkOutput("vis_h799",       32'(d_visible), 32'd1);
            800:  begin
                     checkOutput("vis_h800",    32'(d_visible), 32'd0);
                     checkOutput("blank_h800",  32'(d_blank),   32'd0);
                  end
            801:  checkOutput("blank_h801",     32'(d_blank),   32'd1);
            840:  checkOutput("hsync_h840",     32'(d_hsync),   32'd0);
            841:  checkOutput("hsync_h841",     32'(d_hsync),   32'd1);
            968:  checkOutput("hsync_h968",     32'(d_hsync),   32'd1);
            969:  checkOutput("hsync_h969",     32'(d_hsync),   32'd0);
            1055: begin
                     checkOutput("h_last",      32'(d_h),       32'd1055);
                     checkOutput("v_before",    32'(d_v),       32'd0);
                  end
            1056: begin
                     checkOutput("h_wrap",      32'(d_h),       32'd0);
                     checkOutput("v_step",      32'(d_v),       32'd1);
                     checkOutput("vis_line1",   32'(d_visible), 32'd1);
                     checkOutput("blank_line1", 32'(d_blank),   32'd1);
                     checkOutput("fs_line_wrap",32'(d_fs),      32'd0);
                  end
            1057: checkOutput("blank_line1_h1", 32'(d_blank),   32'd0);
            default: ;
         endcase
      end
      checkOutput("line_seq_errors", 32'(big_err), 32'd0);
      checkOutput("hsync_width",     32'(hs_cnt),  32'd128);

      // small-timing frames
      @(negedge VGA_CLOCK);
      prev_vis  = s_visible;
      rst_small = 1'b1;
      stepTo(1);
      checkOutput("s_first_h", 32'(s_h), 32'd1);
      stepTo(149);
      checkOutput("s_no_fs_reset_frame", 32'(pulses), 32'd0);
      stepTo(150);
      checkOutput("s_fs_pulse", 32'(s_fs), 32'd1);
      checkOutput("s_fc_1",     32'(s_fc), 32'd1);
      checkOutput("s_wrap_h",   32'(s_h),  32'd0);
      checkOutput("s_wrap_v",   32'(s_v),  32'd0);
      stepTo(151);
      checkOutput("s_fs_one_cycle", 32'(s_fs), 32'd0);
      stepTo(255);
      checkOutput("vsync_v7h0", 32'(s_vsync), 32'd0);
      stepTo(256);
      checkOutput("vsync_v7h1", 32'(s_vsync), 32'd1);
      stepTo(285);
      checkOutput("vsync_v9h0", 32'(s_vsync), 32'd1);
      stepTo(286);
      checkOutput("vsync_v9h1", 32'(s_vsync), 32'd0);
      stepTo(300);
      checkOutput("vsync_frame_cnt",   32'(vs_cnt),  32'd30);
      checkOutput("visible_frame_cnt", 32'(vis_cnt), 32'd48);
      stepTo(449);
      checkOutput("fs_pulses_3frames", 32'(pulses),   32'd2);
      checkOutput("fs_gap",            32'(last_gap), 32'd150);
      checkOutput("fc_3frames",        32'(s_fc),     32'd2);
      stepTo(38250);
      checkOutput("fc_255", 32'(s_fc), 32'd255);
      stepTo(38400);
      checkOutput("fc_wrap",    32'(s_fc), 32'd0);
      checkOutput("fs_at_wrap", 32'(s_fs), 32'd1);
      stepTo(38450);
      checkOutput("pre_rst_h", 32'(s_h), 32'd5);
      checkOutput("pre_rst_v", 32'(s_v), 32'd3);

      // asynchronous mid-frame reset between edges
      #2;
      rst_small = 1'b0;
      #1;
      checkResetState("midrst");
      @(negedge VGA_CLOCK);
      @(negedge VGA_CLOCK);
      checkOutput("midrst_held_h", 32'(s_h), 32'd0);
      prev_vis     = s_visible;
      rst_small    = 1'b1;
      sk           = 0;
      pulses       = 0;
      last_pulse_k = -1;
      stepTo(1);
      checkOutput("restart_h", 32'(s_h), 32'd1);
      checkOutput("restart_v", 32'(s_v), 32'd0);
      stepTo(150);
      checkOutput("restart_fs",     32'(s_fs),         32'd1);
      checkOutput("restart_fc",     32'(s_fc),         32'd1);
      checkOutput("restart_pulses", 32'(pulses),       32'd1);
      checkOutput("restart_fs_at",  32'(last_pulse_k), 32'd150);
      stepTo(160);
      checkOutput("per_clock_invariants", 32'(inv_err), 32'd0);
   endtask

   // main sequence
   initial begin
      applyStimulus();
      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_VISIBLE 800 (active pixels/line); H_FRONT 40; H_SYNC 128; H_BACK 88; V_VISIBLE 600 (active lines); V_FRONT 1; V_SYNC 4; V_BACK 23; SYNC_POL 1 (active sync level).
REQ-002 SHALL have port VGA_CLOCK  input  1  pixel clock, the block's only clock, all state on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port PIXEL_H  output  11  current horizontal position, 0..H_TOTAL-1.
REQ-005 SHALL have port PIXEL_V  output  11  current vertical position, 0..V_TOTAL-1.
REQ-006 SHALL have port VISIBLE  output  1  high when PIXEL_H < H_VISIBLE and PIXEL_V < V_VISIBLE, aligned with PIXEL_H/PIXEL_V.
REQ-007 SHALL have port HSYNC  output  1  horizontal sync, one cycle behind counters.
REQ-008 SHALL have port VSYNC  output  1  vertical sync, one cycle behind counters.
REQ-009 SHALL have port BLANK  output  1  inverse of VISIBLE, one cycle behind counters.
REQ-010 SHALL have port FRAME_START  output  1  one-cycle pulse while counters read (0,0) after a frame wrap.
REQ-011 SHALL have port FRAME_COUNT  output  8  completed-frame counter, wraps 255->0.

Function
REQ-012 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 1056) and V_TOTAL likewise (default 628).
REQ-013 SHALL increment PIXEL_H by 1 every clock; at H_TOTAL-1 it wraps to 0 on the next clock.
REQ-014 SHALL increment PIXEL_V only on the clock where PIXEL_H wraps; at V_TOTAL-1 with PIXEL_H = H_TOTAL-1 both wrap to 0.
REQ-015 SHALL register all outputs; VISIBLE and FRAME_START change on the same edge as the counters.
REQ-016 SHALL assert HSYNC = SYNC_POL in the cycle after PIXEL_H is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (default 840..967), else !SYNC_POL.
REQ-017 SHALL assert VSYNC = SYNC_POL in the cycle after PIXEL_V is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (default 601..604), independent of PIXEL_H, else !SYNC_POL.
REQ-018 SHALL delay HSYNC/VSYNC/BLANK by exactly one clock so they align with a downstream stage that registers pixel colour from PIXEL_H/PIXEL_V.
REQ-019 SHALL assert FRAME_START for exactly one clock each time both counters wrap to (0,0), and increment FRAME_COUNT on that same edge.
REQ-020 SHALL produce exactly H_TOTAL*V_TOTAL clocks (default 663168) between consecutive FRAME_START pulses.
REQ-021 SHALL hold PIXEL_H/PIXEL_V within range at all times; no value >= H_TOTAL/V_TOTAL ever appears.

Reset
REQ-022 SHALL, while RESET = 0 regardless of clock, drive PIXEL_H = 0, PIXEL_V = 0, VISIBLE = 1, HSYNC = VSYNC = !SYNC_POL, BLANK = 1, FRAME_START = 0, FRAME_COUNT = 0.
REQ-023 SHALL, on the first rising edge after RESET returns to 1, advance PIXEL_H to 1; the frame begun by reset produces no FRAME_START.
REQ-024 SHALL, on RESET asserted mid-frame, return all outputs to REQ-022 values immediately, with no partial-frame FRAME_START.

Verification
REQ-025 Release reset, run 1056 clocks -> PIXEL_H reads 0..1055 then 0, PIXEL_V steps 0->1 on the wrap edge.
REQ-026 Counters at H=839 then 840 -> HSYNC rises one clock after PIXEL_H = 840 and falls one clock after PIXEL_H = 968; width 128 clocks.
REQ-027 Run full frame -> VSYNC high for 4*1056 = 4224 clocks starting one clock after (H=0,V=601); VISIBLE high 800*600 = 480000 clocks per frame.
REQ-028 Run 3 frames from reset -> FRAME_START pulses exactly 2 times, 663168 clocks apart, FRAME_COUNT = 2 and FRAME_COUNT wraps 255->0 after 256 frames.
REQ-029 Assert RESET at H=500,V=300 asynchronously between edges -> all outputs match REQ-022 before next edge; after release timing restarts from (0,0).
REQ-030 Every clock, check BLANK(t) = !VISIBLE(t-1) and PIXEL_H < 1056, PIXEL_V < 628.
